// File: rtl/wb_uart_txfifo_if.sv
// Bus-side, RAM-side and serializer-side signals of the UART transmit FIFO.
interface wb_uart_txfifo_if #(
    parameter int p_DW = 8,
    parameter int p_AW = 3
);
    logic            i_flush;
    logic            i_wr;
    logic [p_DW-1:0] iv_wr_data;
    logic            o_full;
    logic            o_wr_ovf;
    logic [p_AW:0]   ov_level;
    logic            o_we_a;
    logic [p_AW-1:0] ov_addr_a;
    logic [p_DW-1:0] ov_data_a;
    logic            o_rd_b;
    logic [p_AW-1:0] ov_addr_b;
    logic [p_DW-1:0] iv_data_b;
    logic            o_rd_valid;
    logic [p_DW-1:0] ov_rd_data;
    logic            i_rd_ready;

    // FIFO controller side
    modport slave (
        input  i_flush, i_wr, iv_wr_data, iv_data_b, i_rd_ready,
        output o_full, o_wr_ovf, ov_level, o_we_a, ov_addr_a, ov_data_a,
        output o_rd_b, ov_addr_b, o_rd_valid, ov_rd_data
    );

    // Environment side: bus writer, RAM and serializer
    modport master (
        output i_flush, i_wr, iv_wr_data, iv_data_b, i_rd_ready,
        input  o_full, o_wr_ovf, ov_level, o_we_a, ov_addr_a, ov_data_a,
        input  o_rd_b, ov_addr_b, o_rd_valid, ov_rd_data
    );
endinterface

// File: rtl/wb_uart_txfifo.sv
// UART transmit FIFO controller around an external two-port RAM with a
// registered read port. The RAM output register acts as the presented word
// (first-word-fall-through), so vld_q marks whether iv_data_b is live.
module wb_uart_txfifo #(
    parameter int p_DW = 8,
    parameter int p_AW = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    wb_uart_txfifo_if.slave bus
);
    localparam logic [p_AW:0]   DEPTH_C   = (p_AW + 1)'(2 ** p_AW);
    localparam logic [p_AW:0]   CNT_ONE   = (p_AW + 1)'(1);
    localparam logic [p_AW-1:0] PTR_ONE   = p_AW'(1);

    logic [p_AW-1:0] wptr_q, wptr_d;
    logic [p_AW-1:0] rptr_q, rptr_d;
    logic [p_AW:0]   mcnt_q, mcnt_d;
    logic            vld_q, vld_d;
    logic            ovf_q, ovf_d;
    logic            full;
    logic            wr_ok;
    logic            fetch;
    logic            block;

    // Handshake decode on current state; reset and flush suppress RAM access
    always_comb begin
        block = i_rst | bus.i_flush;
        full  = (mcnt_q == DEPTH_C);
        wr_ok = bus.i_wr & ~full & ~block;
        fetch = (mcnt_q != '0) & (~vld_q | bus.i_rd_ready) & ~block;
    end

    assign bus.o_full     = full;
    assign bus.o_wr_ovf   = ovf_q;
    assign bus.ov_level   = mcnt_q + {{p_AW{1'b0}}, vld_q};
    assign bus.o_we_a     = wr_ok;
    assign bus.ov_addr_a  = wptr_q;
    assign bus.ov_data_a  = bus.iv_wr_data;
    assign bus.o_rd_b     = fetch;
    assign bus.ov_addr_b  = rptr_q;
    assign bus.o_rd_valid = vld_q;
    assign bus.ov_rd_data = bus.iv_data_b;

    // Next-state: pointers, unfetched count, output-stage flag, overflow pulse
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mcnt_d = mcnt_q;
        vld_d  = vld_q;
        ovf_d  = 1'b0;
        if (bus.i_flush) begin
            wptr_d = '0;
            rptr_d = '0;
            mcnt_d = '0;
            vld_d  = 1'b0;
        end else begin
            ovf_d = bus.i_wr & full;
            if (wr_ok) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (fetch) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            unique case ({wr_ok, fetch})
                2'b10:   mcnt_d = mcnt_q + CNT_ONE;
                2'b01:   mcnt_d = mcnt_q - CNT_ONE;
                default: mcnt_d = mcnt_q;
            endcase
            if (fetch) begin
                vld_d = 1'b1;
            end else if (vld_q & bus.i_rd_ready) begin
                vld_d = 1'b0;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            mcnt_q <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mcnt_q <= mcnt_d;
            vld_q  <= vld_d;
            ovf_q  <= ovf_d;
        end
    end
endmodule

// File: tb/tb_wb_uart_txfifo.sv
// Bench for wb_uart_txfifo: RAM model, queue-based reference and scoreboard.
module tb_wb_uart_txfifo;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;

    logic clk;
    logic rst;

    wb_uart_txfifo_if #(.p_DW(DW), .p_AW(AW)) ifc ();

    wb_uart_txfifo #(.p_DW(DW), .p_AW(AW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifc.slave)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-port RAM with registered read port
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ifc.o_we_a) mem[ifc.ov_addr_a] <= ifc.ov_data_a;
        if (ifc.o_rd_b) ifc.iv_data_b <= mem[ifc.ov_addr_b];
    end

    // Reference model: words in RAM, presented word, pending overflow pulse
    logic [DW-1:0] mq[$];
    logic [DW-1:0] sb_q[$];
    bit            pv;
    logic [DW-1:0] pw;
    bit            ovf_e;
    logic [DW-1:0] sb_exp;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare at negedge, advance model at posedge
    task automatic step(input bit wr, input logic [DW-1:0] d, input bit rdy,
                        input bit fl, input bit rs);
        bit full_e, fetch_e, acc;
        rst            = rs;
        ifc.i_wr       = wr;
        ifc.iv_wr_data = d;
        ifc.i_rd_ready = rdy;
        ifc.i_flush    = fl;
        @(negedge clk);
        full_e  = (mq.size() == DEPTH);
        fetch_e = (mq.size() != 0) && (!pv || rdy) && !fl && !rs;
        acc     = wr && !full_e && !fl && !rs;
        chk("full", 32'(ifc.o_full), 32'(full_e));
        chk("level", 32'(ifc.ov_level), 32'(mq.size() + int'(pv)));
        chk("rd_valid", 32'(ifc.o_rd_valid), 32'(pv));
        if (pv) chk("rd_data", 32'(ifc.ov_rd_data), 32'(pw));
        chk("wr_ovf", 32'(ifc.o_wr_ovf), 32'(ovf_e));
        chk("we_a", 32'(ifc.o_we_a), 32'(acc));
        if (acc) chk("data_a", 32'(ifc.ov_data_a), 32'(d));
        chk("rd_b", 32'(ifc.o_rd_b), 32'(fetch_e));
        @(posedge clk);
        if (rs || fl) begin
            mq.delete();
            sb_q.delete();
            pv    = 1'b0;
            ovf_e = 1'b0;
        end else begin
            ovf_e = wr && full_e;
            if (fetch_e) begin
                pw = mq.pop_front();
                pv = 1'b1;
            end else if (pv && rdy) begin
                pv = 1'b0;
            end
            if (acc) begin
                mq.push_back(d);
                sb_q.push_back(d);
            end
        end
        #1;
    endtask

    // Scoreboard monitor: every accepted word must be the oldest written word
    always @(negedge clk) begin
        if (rst !== 1'b1 && ifc.o_rd_valid === 1'b1 && ifc.i_rd_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: word %0h accepted, none expected", ifc.ov_rd_data);
            end else begin
                sb_exp = sb_q.pop_front();
                chk("sb_order", 32'(ifc.ov_rd_data), 32'(sb_exp));
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        ifc.i_wr = 1'b0;
        ifc.iv_wr_data = '0;
        ifc.i_rd_ready = 1'b0;
        ifc.i_flush = 1'b0;
        pv = 1'b0;
        pw = '0;
        ovf_e = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("reset_level", 32'(ifc.ov_level), 32'd0);
        chk("reset_valid", 32'(ifc.o_rd_valid), 32'd0);

        // Single word latency into an idle FIFO
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("lat_valid", 32'(ifc.o_rd_valid), 32'd1);
        chk("lat_data", 32'(ifc.ov_rd_data), 32'hA5);
        chk("lat_level", 32'(ifc.ov_level), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("hold_data", 32'(ifc.ov_rd_data), 32'hA5);
        drain(3);

        // Fill past capacity with the reader stalled
        for (int i = 0; i < 10; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_full", 32'(ifc.o_full), 32'd1);
        chk("fill_level", 32'(ifc.ov_level), 32'd9);
        chk("fill_ovf", 32'(ifc.o_wr_ovf), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("ovf_single", 32'(ifc.o_wr_ovf), 32'd0);

        // Write while full with reader accepting: write dropped
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        chk("wfull_ovf", 32'(ifc.o_wr_ovf), 32'd1);
        chk("wfull_level", 32'(ifc.ov_level), 32'd8);
        chk("wfull_full", 32'(ifc.o_full), 32'd0);
        drain(12);

        // Streaming with reader always ready
        for (int i = 0; i < 20; i++) step(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
        drain(4);

        // Flush and reset with words stored and one presented
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 6; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, 1'b0);
            chk("pre_clr_level", 32'(ifc.ov_level), 32'd6);
            step(1'b0, '0, 1'b0, (k == 0), (k == 1));
            chk("clr_level", 32'(ifc.ov_level), 32'd0);
            chk("clr_valid", 32'(ifc.o_rd_valid), 32'd0);
            chk("clr_full", 32'(ifc.o_full), 32'd0);
            step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
            step(1'b0, '0, 1'b0, 1'b0, 1'b0);
            chk("clr_first", 32'(ifc.ov_rd_data), 32'h3C);
            drain(2);
        end

        // Randomized traffic with phases of varying reader readiness
        for (int i = 0; i < 600; i++) begin
            int rp;
            rp = (i / 100) % 3;
            step(($urandom_range(0, 3) != 0), DW'($urandom),
                 (rp == 0) ? ($urandom_range(0, 3) == 0) :
                 (rp == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 79) == 0), ($urandom_range(0, 149) == 0));
        end
        drain(DEPTH + 4);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
